// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq.
// The master drives requests and accepts results; the slave is the ALU.
interface alu_seq_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic [3:0]      alu_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_data;
    logic            busy;

    modport master (
        output in_valid, operand_a, operand_b, alu_op, out_ready,
        input  in_ready, out_valid, alu_data, busy
    );

    modport slave (
        input  in_valid, operand_a, operand_b, alu_op, out_ready,
        output in_ready, out_valid, alu_data, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops, plus
// iterative shift-add MUL and restoring DIVU (one bit per cycle).
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | MUL/DIVU iterating, counter counts down from XLEN
// DONE  | result valid, waiting for out_ready
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_XOR   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_LSR   = 4'b0111;
    localparam logic [3:0] OP_LSL   = 4'b1000;
    localparam logic [3:0] OP_PASSB = 4'b1001;
    localparam logic [3:0] OP_ASR   = 4'b1010;
    localparam logic [3:0] OP_LT    = 4'b1011;
    localparam logic [3:0] OP_LTU   = 4'b1100;
    localparam logic [3:0] OP_PASSA = 4'b1101;
    localparam logic [3:0] OP_MUL   = 4'b1110;
    localparam logic [3:0] OP_DIVU  = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] opa_q, opb_q, acc_q, alu_data_q;
    logic            is_div_q;

    logic            accept, is_multi, last_iter;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] single_res;
    logic [XLEN-1:0] mul_acc;
    logic [XLEN:0]   div_trial;
    logic            div_ge;
    logic [XLEN-1:0] div_rem, div_quo;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign is_multi  = (bus.alu_op == OP_MUL) || (bus.alu_op == OP_DIVU);
    assign last_iter = (cnt_q == CW'(1));
    assign sh        = bus.operand_b[SHW-1:0];

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.out_valid = (state_q == DONE);
    assign bus.alu_data  = alu_data_q;

    // Single-cycle result straight from the live request inputs.
    always_comb begin
        single_res = '0;
        case (bus.alu_op)
            OP_ADD:   single_res = bus.operand_a + bus.operand_b;
            OP_SUB:   single_res = bus.operand_a - bus.operand_b;
            OP_XOR:   single_res = bus.operand_a ^ bus.operand_b;
            OP_OR:    single_res = bus.operand_a | bus.operand_b;
            OP_AND:   single_res = bus.operand_a & bus.operand_b;
            OP_LSR:   single_res = bus.operand_a >> sh;
            OP_LSL:   single_res = bus.operand_a << sh;
            OP_PASSB: single_res = bus.operand_b;
            OP_PASSA: single_res = bus.operand_a;
            OP_ASR:   single_res = $unsigned($signed(bus.operand_a) >>> sh);
            OP_LT:    single_res = {{(XLEN-1){1'b0}},
                                    ($signed(bus.operand_a) < $signed(bus.operand_b))};
            OP_LTU:   single_res = {{(XLEN-1){1'b0}}, (bus.operand_a < bus.operand_b)};
            default:  single_res = '0;
        endcase
    end

    // One iteration step: shift-add for MUL, restoring trial subtract for DIVU.
    // A zero divisor always "fits", so the quotient naturally becomes all ones.
    always_comb begin
        mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
        div_trial = {acc_q, opa_q[XLEN-1]};
        div_ge    = (div_trial >= {1'b0, opb_q});
        div_rem   = div_ge ? XLEN'(div_trial - {1'b0, opb_q}) : div_trial[XLEN-1:0];
        div_quo   = {opa_q[XLEN-2:0], div_ge};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_multi ? BUSY : DONE;
            BUSY:    if (last_iter) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            is_div_q   <= 1'b0;
            alu_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_multi) begin
                            opa_q    <= bus.operand_a;
                            opb_q    <= bus.operand_b;
                            acc_q    <= '0;
                            is_div_q <= (bus.alu_op == OP_DIVU);
                            cnt_q    <= CW'(XLEN);
                        end else begin
                            alu_data_q <= single_res;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (is_div_q) begin
                        acc_q <= div_rem;
                        opa_q <= div_quo;
                    end else begin
                        acc_q <= mul_acc;
                        opa_q <= opa_q << 1;
                        opb_q <= opb_q >> 1;
                    end
                    if (last_iter) alu_data_q <= is_div_q ? div_quo : mul_acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vectors plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_alu_seq;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_seq_if #(.XLEN(XLEN)) bus ();

    alu_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        logic [63:0] prod;
        s = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd5:    return a | b;
            4'd6:    return a & b;
            4'd7:    return a >> s;
            4'd8:    return a << s;
            4'd9:    return b;
            4'd13:   return a;
            4'd10:   return $unsigned($signed(a) >>> s);
            4'd11:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return (a < b) ? 32'd1 : 32'd0;
            4'd14: begin
                prod = 64'(a) * 64'(b);
                return prod[31:0];
            end
            4'd15:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one request, check latency/busy/result, optionally hold off out_ready for bp cycles.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int bp);
        int lat;
        int busy_cnt;
        bit multi;
        multi = (op == 4'd14) || (op == 4'd15);
        bus.in_valid  = 1'b1;
        bus.alu_op    = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.out_ready = (bp == 0);
        check("in_ready_before", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.alu_op    = 4'($urandom_range(15));
        lat = 1;
        busy_cnt = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), multi ? 64'(XLEN + 1) : 64'd1);
        check("busy_cycles", 64'(busy_cnt), multi ? 64'(XLEN) : 64'd0);
        check("result", 64'(bus.alu_data), 64'(exp));
        if (bp > 0) begin
            bus.in_valid  = 1'b1;
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
            bus.alu_op    = 4'd0;
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_data_stable", 64'(bus.alu_data), 64'(exp));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("idle_out_valid", 64'(bus.out_valid), 64'd0);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);
        check("idle_data_hold", 64'(bus.alu_data), 64'(exp));
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int          bp;
        int          seen;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.alu_op    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_alu_data", 64'(bus.alu_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors with hand-computed expectations.
        do_op(4'b0000, 32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 0);
        do_op(4'b1011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0);
        do_op(4'b1100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 0);
        do_op(4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0);
        do_op(4'b1110, 32'd6, 32'd7, 32'd42, 0);
        do_op(4'b1110, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0);
        do_op(4'b1111, 32'd100, 32'd7, 32'd14, 0);
        do_op(4'b1111, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        do_op(4'b0011, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 0);
        do_op(4'b0100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 0);
        do_op(4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE, 5);
        do_op(4'b0111, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0F00_0000, 0);
        do_op(4'b1000, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(15));
            a  = $urandom;
            b  = $urandom;
            if (op == 4'd15 && (i % 3) == 0) b = $urandom_range(9);
            if (op == 4'd14 && (i % 2) == 0) b = $urandom_range(1000);
            bp = ((i % 5) == 0) ? int'($urandom_range(3, 1)) : 0;
            do_op(op, a, b, ref_alu(op, a, b), bp);
        end

        // Reset in the middle of a MUL must abort it with no late result.
        bus.in_valid  = 1'b1;
        bus.alu_op    = 4'b1110;
        bus.operand_a = 32'd123;
        bus.operand_b = 32'd456;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("mid_mul_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check("abort_alu_data", 64'(bus.alu_data), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_stale_result", 64'(seen), 64'd0);

        // Normal operation resumes after the abort.
        do_op(4'b1110, 32'd9, 32'd9, 32'd81, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
